// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory access unit: funct3 size codes, FSM
// state encodings and store lane helpers.
package mem_access_unit_pkg;

    // funct3 access size / signedness codes
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    // Access width classes derived from funct3
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Unlisted funct3 encodings (011, 110, 111) fall through to word.
    function automatic logic [1:0] access_size(input logic [2:0] f3);
        case (f3)
            MEM_B, MEM_BU: access_size = SZ_B;
            MEM_H, MEM_HU: access_size = SZ_H;
            default:       access_size = SZ_W;
        endcase
    endfunction

    // Byte enables for a store; low address bits beyond the access
    // width are ignored.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (access_size(f3))
            SZ_B:    store_be = 4'b0001 << off;
            SZ_H:    store_be = off[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Replicate the store operand across every lane it could occupy, so
    // the byte enables alone select the destination bytes.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (access_size(f3))
            SZ_B:    store_lanes = {4{d[7:0]}};
            SZ_H:    store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data alignment: picks the addressed byte/half out of the returned
// cache word and sign- or zero-extends it to a full register value.
module load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection by the low address bits
    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension by access type; word-class codes pass the word through
    always_comb begin
        data = rdata;
        case (funct3)
            MEM_B:   data = {{24{byte_sel[7]}}, byte_sel};
            MEM_BU:  data = {24'd0, byte_sel};
            MEM_H:   data = {{16{half_sel[15]}}, half_sel};
            MEM_HU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: turns the ALU result into an L1 data cache access for
// loads/stores (req/gnt/rvalid), or forwards it for other instructions,
// and produces one writeback record per accepted instruction.
// Optional misaligned-access exception enabled by MEM_MISALIGN_EXC_EN.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_alu_out,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [REGW-1:0] in_rd,
    input  logic            in_reg_we,
    output logic            dc_req,
    output logic            dc_we,
    output logic [XLEN-1:0] dc_addr,
    output logic [XLEN-1:0] dc_wdata,
    output logic [3:0]      dc_be,
    input  logic            dc_gnt,
    input  logic            dc_rvalid,
    input  logic [XLEN-1:0] dc_rdata,
    output logic            wb_valid,
    output logic [REGW-1:0] wb_rd,
    output logic            wb_reg_we,
    output logic [XLEN-1:0] wb_data,
    output logic            mem_exc
);

    state_t state_q, state_d;

    // Latched memory instruction
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] sdata_q;
    logic [2:0]      funct3_q;
    logic [REGW-1:0] rd_q;
    logic            reg_we_q;
    logic            is_store_q;

    logic            accept;
    logic            is_mem;
    logic            is_store;
    logic            misalign;
    logic [XLEN-1:0] load_word;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid & in_ready;
    assign is_mem   = in_is_load | in_is_store;
    // Load wins when both flags are set
    assign is_store = in_is_store & ~in_is_load;

`ifdef MEM_MISALIGN_EXC_EN
    logic [1:0] in_size;
    assign in_size  = access_size(in_funct3);
    assign misalign = is_mem &
                      (((in_size == SZ_H) & in_alu_out[0]) |
                       ((in_size == SZ_W) & (in_alu_out[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    load_align u_load_align (
        .rdata  (dc_rdata),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (load_word)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: gnt ends REQ, rvalid is only honoured in WAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && is_mem && !misalign) state_d = ST_REQ;
            ST_REQ:  if (dc_gnt) state_d = is_store_q ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (dc_rvalid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the memory instruction at accept
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            sdata_q    <= '0;
            funct3_q   <= 3'b000;
            rd_q       <= '0;
            reg_we_q   <= 1'b0;
            is_store_q <= 1'b0;
        end else if (accept && is_mem && !misalign) begin
            addr_q     <= in_alu_out;
            sdata_q    <= in_store_data;
            funct3_q   <= in_funct3;
            rd_q       <= in_rd;
            reg_we_q   <= in_reg_we;
            is_store_q <= is_store;
        end
    end

    // Cache request decoded from registered state only, so reset drops it at once
    always_comb begin
        dc_req   = 1'b0;
        dc_we    = 1'b0;
        dc_addr  = '0;
        dc_wdata = '0;
        dc_be    = 4'b0000;
        if (state_q == ST_REQ) begin
            dc_req  = 1'b1;
            dc_addr = {addr_q[XLEN-1:2], 2'b00};
            if (is_store_q) begin
                dc_we    = 1'b1;
                dc_be    = store_be(funct3_q, addr_q[1:0]);
                dc_wdata = store_lanes(funct3_q, sdata_q);
            end else begin
                dc_be    = 4'b1111;
            end
        end
    end

    // Writeback record: single-cycle pulse per completed instruction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_reg_we <= 1'b0;
            wb_data   <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept && (!is_mem || misalign)) begin
                        wb_valid  <= 1'b1;
                        wb_rd     <= in_rd;
                        wb_data   <= in_alu_out;
                        wb_reg_we <= !is_mem && in_reg_we && (in_rd != '0);
                    end
                end
                ST_REQ: begin
                    if (dc_gnt && is_store_q) begin
                        wb_valid  <= 1'b1;
                        wb_rd     <= rd_q;
                        wb_data   <= addr_q;
                        wb_reg_we <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (dc_rvalid) begin
                        wb_valid  <= 1'b1;
                        wb_rd     <= rd_q;
                        wb_data   <= load_word;
                        wb_reg_we <= reg_we_q && (rd_q != '0);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_MISALIGN_EXC_EN
    // Exception flag travels with the writeback pulse of the faulting access
    always_ff @(posedge clock or posedge reset) begin
        if (reset) mem_exc <= 1'b0;
        else       mem_exc <= (state_q == ST_IDLE) && accept && misalign;
    end
`else
    assign mem_exc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: writeback records are checked
// against a queue of expected results; cache handshakes are driven by hand.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_is_load = 1'b0;
    logic        in_is_store = 1'b0;
    logic [2:0]  in_funct3 = 3'b000;
    logic [31:0] in_alu_out = '0;
    logic [31:0] in_store_data = '0;
    logic [4:0]  in_rd = '0;
    logic        in_reg_we = 1'b0;
    logic        dc_req, dc_we;
    logic [31:0] dc_addr, dc_wdata;
    logic [3:0]  dc_be;
    logic        dc_gnt = 1'b0;
    logic        dc_rvalid = 1'b0;
    logic [31:0] dc_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_we;
    logic [31:0] wb_data;
    logic        mem_exc;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic        chk_data;
        logic        exc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    mem_access_unit #(.XLEN(32), .REGW(5)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_alu_out(in_alu_out),
        .in_store_data(in_store_data), .in_rd(in_rd), .in_reg_we(in_reg_we),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_be(dc_be), .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
        .wb_data(wb_data), .mem_exc(mem_exc)
    );

    // Scoreboard: every writeback pulse must match the oldest expectation
    always @(negedge clock) begin
        exp_t e;
        if (!reset && wb_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got wb_valid rd=%0d data=%h, none expected", wb_rd, wb_data);
            end else begin
                e = sb.pop_front();
                if (wb_rd !== e.rd || wb_reg_we !== e.we || mem_exc !== e.exc ||
                    (e.chk_data && wb_data !== e.data)) begin
                    n_fail++;
                    $display("FAIL wb_record: got rd=%0d we=%b exc=%b data=%h, expected rd=%0d we=%b exc=%b data=%h",
                             wb_rd, wb_reg_we, mem_exc, wb_data, e.rd, e.we, e.exc, e.data);
                end
            end
        end
    end

    function automatic exp_t mk(input logic [4:0] rd, input logic we, input logic [31:0] d,
                                input logic chk, input logic exc);
        exp_t e;
        e.rd = rd; e.we = we; e.data = d; e.chk_data = chk; e.exc = exc;
        return e;
    endfunction

    // Present one instruction for a single cycle; call at posedge+1 with the unit idle
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input logic we);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_alu_out = a; in_store_data = d; in_rd = rd; in_reg_we = we;
        @(posedge clock); #1;
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d writebacks outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++;
        if (dc_req !== 1'b0 || dc_be !== 4'b0 || dc_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_dc: got req=%b be=%b addr=%h expected 0", dc_req, dc_be, dc_addr);
        end
        n_checks++;
        if (wb_valid !== 1'b0 || mem_exc !== 1'b0 || wb_data !== 32'h0 || wb_reg_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_wb: got v=%b exc=%b we=%b data=%h expected 0", wb_valid, mem_exc, wb_reg_we, wb_data);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_alu;
        sb.push_back(mk(5'd5, 1'b1, 32'h1234, 1'b1, 1'b0));
        issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
        @(negedge clock);
        n_checks++;
        if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_latency: got wb_valid=%b expected 1", wb_valid); end
        @(posedge clock); #1;
        sb.push_back(mk(5'd0, 1'b0, 32'h1234, 1'b1, 1'b0));
        issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd0, 1'b1);
        wait_drain("alu");
    endtask

    task automatic test_back_to_back;
        in_valid = 1'b1; in_reg_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_alu_out = 32'hA000 + i; in_rd = 5'(10 + i);
            sb.push_back(mk(5'(10 + i), 1'b1, 32'hA000 + i, 1'b1, 1'b0));
            @(posedge clock); #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
        end
        in_valid = 1'b0;
        wait_drain("b2b");
    endtask

    task automatic test_load_align;
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        logic [31:0] adrs [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
        logic [31:0] rds  [5] = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_0000, 32'h8001_0000, 32'h1234_567F};
        logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h0000_007F};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(mk(5'd7, 1'b1, exps[i], 1'b1, 1'b0));
            issue(1'b1, 1'b0, f3s[i], adrs[i], 32'h0, 5'd7, 1'b1);
            dc_gnt = 1'b1;
            @(negedge clock);
            n_checks++;
            if (dc_req !== 1'b1 || dc_we !== 1'b0 || dc_be !== 4'b1111 || dc_addr !== {adrs[i][31:2], 2'b00} || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL load%0d_req: got req=%b we=%b be=%b addr=%h rdy=%b expected 1 0 1111 %h 0",
                         i, dc_req, dc_we, dc_be, dc_addr, in_ready, {adrs[i][31:2], 2'b00});
            end
            @(posedge clock); #1;
            dc_gnt = 1'b0; dc_rvalid = 1'b1; dc_rdata = rds[i];
            @(negedge clock);
            n_checks++;
            if (dc_req !== 1'b0) begin n_fail++; $display("FAIL load%0d_wait_req: got %b expected 0", i, dc_req); end
            @(posedge clock); #1;
            dc_rvalid = 1'b0;
            @(negedge clock);
            n_checks++;
            if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL load%0d_latency: got wb_valid=%b expected 1", i, wb_valid); end
            @(posedge clock); #1;
        end
        wait_drain("load");
    endtask

    task automatic test_store_delayed_gnt;
        sb.push_back(mk(5'd0, 1'b0, 32'h0, 1'b0, 1'b0));
        issue(1'b0, 1'b1, 3'b001, 32'h202, 32'hABCD_1234, 5'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            dc_gnt = (c == 3);
            @(negedge clock);
            n_checks++;
            if (dc_req !== 1'b1 || dc_we !== 1'b1 || dc_be !== 4'b1100 || dc_wdata !== 32'h1234_1234 ||
                dc_addr !== 32'h200 || in_ready !== 1'b0 || wb_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL sh_hold%0d: got req=%b we=%b be=%b wdata=%h addr=%h rdy=%b wbv=%b expected 1 1 1100 12341234 200 0 0",
                         c, dc_req, dc_we, dc_be, dc_wdata, dc_addr, in_ready, wb_valid);
            end
            @(posedge clock); #1;
        end
        dc_gnt = 1'b0;
        @(negedge clock);
        n_checks++;
        if (wb_valid !== 1'b1 || dc_req !== 1'b0) begin
            n_fail++; $display("FAIL sh_done: got wb_valid=%b dc_req=%b expected 1 0", wb_valid, dc_req);
        end
        @(posedge clock); #1;
        wait_drain("sh");
    endtask

    task automatic test_store_lanes;
        logic [2:0]  f3s [2] = '{3'b000, 3'b010};
        logic [31:0] adrs[2] = '{32'h301, 32'h300};
        logic [31:0] ds  [2] = '{32'h1122_335A, 32'hCAFE_F00D};
        logic [3:0]  bes [2] = '{4'b0010, 4'b1111};
        logic [31:0] wds [2] = '{32'h5A5A_5A5A, 32'hCAFE_F00D};
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(5'd3, 1'b0, 32'h0, 1'b0, 1'b0));
            issue(1'b0, 1'b1, f3s[i], adrs[i], ds[i], 5'd3, 1'b1);
            dc_gnt = 1'b1;
            @(negedge clock);
            n_checks++;
            if (dc_be !== bes[i] || dc_wdata !== wds[i] || dc_we !== 1'b1) begin
                n_fail++;
                $display("FAIL store%0d_lanes: got be=%b wdata=%h we=%b expected %b %h 1", i, dc_be, dc_wdata, dc_we, bes[i], wds[i]);
            end
            @(posedge clock); #1;
            dc_gnt = 1'b0;
        end
        wait_drain("store");
    endtask

    task automatic test_lw_slow_rvalid;
        // both load and store flags set: must behave as a load
        sb.push_back(mk(5'd12, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0));
        issue(1'b1, 1'b1, 3'b010, 32'h400, 32'h1111_1111, 5'd12, 1'b1);
        dc_gnt = 1'b1;
        @(negedge clock);
        n_checks++;
        if (dc_we !== 1'b0 || dc_be !== 4'b1111) begin
            n_fail++; $display("FAIL lw_as_load: got we=%b be=%b expected 0 1111", dc_we, dc_be);
        end
        @(posedge clock); #1;
        dc_gnt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            n_checks++;
            if (wb_valid !== 1'b0 || dc_req !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL lw_wait%0d: got wbv=%b req=%b rdy=%b expected 0 0 0", c, wb_valid, dc_req, in_ready);
            end
            @(posedge clock); #1;
        end
        dc_rvalid = 1'b1; dc_rdata = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        dc_rvalid = 1'b0; dc_rdata = 32'h0;
        @(negedge clock);
        n_checks++;
        if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL lw_pulse: got wb_valid=%b expected 1", wb_valid); end
        @(negedge clock);
        n_checks++;
        if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL lw_single: got wb_valid=%b expected 0", wb_valid); end
        @(posedge clock); #1;
        wait_drain("lw");
    endtask

    task automatic test_reset_mid_access;
        issue(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd3, 1'b1);
        dc_gnt = 1'b1;
        @(posedge clock); #1;
        dc_gnt = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (dc_req !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid: got req=%b rdy=%b expected 0 1", dc_req, in_ready);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        dc_rvalid = 1'b1; dc_gnt = 1'b1; dc_rdata = 32'h7777_7777;
        @(posedge clock); #1;
        dc_rvalid = 1'b0; dc_gnt = 1'b0;
        @(negedge clock);
        n_checks++;
        if (wb_valid !== 1'b0 || dc_req !== 1'b0) begin
            n_fail++; $display("FAIL rst_stray: got wbv=%b req=%b expected 0 0", wb_valid, dc_req);
        end
        @(posedge clock); #1;
        sb.push_back(mk(5'd9, 1'b1, 32'h55, 1'b1, 1'b0));
        issue(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd9, 1'b1);
        wait_drain("rst_next");
    endtask

    task automatic test_misalign;
`ifdef MEM_MISALIGN_EXC_EN
        sb.push_back(mk(5'd4, 1'b0, 32'h6, 1'b1, 1'b1));
        issue(1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 5'd4, 1'b1);
        @(negedge clock);
        n_checks++;
        if (dc_req !== 1'b0 || in_ready !== 1'b1 || wb_valid !== 1'b1 || mem_exc !== 1'b1) begin
            n_fail++; $display("FAIL misalign_exc: got req=%b rdy=%b wbv=%b exc=%b expected 0 1 1 1", dc_req, in_ready, wb_valid, mem_exc);
        end
        @(posedge clock); #1;
`else
        sb.push_back(mk(5'd4, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0));
        issue(1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 5'd4, 1'b1);
        dc_gnt = 1'b1;
        @(negedge clock);
        n_checks++;
        if (dc_req !== 1'b1 || dc_addr !== 32'h4 || mem_exc !== 1'b0) begin
            n_fail++; $display("FAIL misalign_noexc: got req=%b addr=%h exc=%b expected 1 00000004 0", dc_req, dc_addr, mem_exc);
        end
        @(posedge clock); #1;
        dc_gnt = 1'b0; dc_rvalid = 1'b1; dc_rdata = 32'h0BAD_F00D;
        @(posedge clock); #1;
        dc_rvalid = 1'b0;
`endif
        wait_drain("misalign");
    endtask

    initial begin
        test_reset;
        test_alu;
        test_back_to_back;
        test_load_align;
        test_store_delayed_gnt;
        test_store_lanes;
        test_lw_slow_rvalid;
        test_reset_mid_access;
        test_misalign;
        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
